zybo_btn_debounce: RTL and testbench

//  Conditions raw Zybo push-button inputs for the LED/timer logic downstream.
//  - Synchronises each button to CLK, debounces it and publishes a clean level.
//  - Emits one-cycle press and release strobes per button.
//  - Sits between the board pins and the LED control block, which consumes only
//    the strobes and levels, never the raw pins.

---
 rtl/zybo_btn_debounce_pkg.sv | 14 +
 rtl/zybo_btn_debounce_ch.sv | 96 +++++++++
 rtl/zybo_btn_debounce.sv | 33 +++
 tb/tb_zybo_btn_debounce.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/zybo_btn_debounce_pkg.sv
// Shared definitions for the Zybo push-button conditioning block: board clock
// rate, default debounce window and the per-channel FSM state encoding.
package zybo_btn_debounce_pkg;

   localparam int CLK_FREQ_HZ             = 125000000;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1250000;
   localparam int DEFAULT_CNT_W           = 21;

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_WAIT   = 1'b1
   } debounceState_t;

endpackage

// File: rtl/zybo_btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, STABLE/WAIT qualification FSM with
// an equality-compared counter, and registered level/press/release outputs.
module zybo_btn_debounce_ch
   import zybo_btn_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEFAULT_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   debounceState_t   r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_press;
   logic             r_release;

   debounceState_t   w_nextState;
   logic [CNT_W-1:0] w_nextCnt;
   logic             w_nextLevel;
   logic             w_nextPress;
   logic             w_nextRelease;

   // Two-stage synchroniser; only the second stage is seen by the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // State, counter, published level and one-cycle strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_STABLE;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_cnt     <= w_nextCnt;
         r_level   <= w_nextLevel;
         r_press   <= w_nextPress;
         r_release <= w_nextRelease;
      end
   end

   // Qualification: any return to the current level restarts from scratch.
   always_comb begin
      w_nextState   = r_state;
      w_nextCnt     = '0;
      w_nextLevel   = r_level;
      w_nextPress   = 1'b0;
      w_nextRelease = 1'b0;
      case (r_state)
         ST_STABLE: begin
            if (r_sync2 != r_level) begin
               w_nextState = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_sync2 == r_level) begin
               w_nextState = ST_STABLE;
            end else if (r_cnt == CNT_LAST) begin
               w_nextState   = ST_STABLE;
               w_nextLevel   = r_sync2;
               w_nextPress   = r_sync2;
               w_nextRelease = ~r_sync2;
            end else begin
               w_nextCnt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_nextState = ST_STABLE;
         end
      endcase
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;

endmodule

// File: rtl/zybo_btn_debounce.sv
// Top level: NUM_BTN independent debounce channels between the board pins and
// the LED control block.
module zybo_btn_debounce
   import zybo_btn_debounce_pkg::*;
#(
   parameter int NUM_BTN         = 4,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEFAULT_CNT_W
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NUM_BTN-1:0] BTN,
   output logic [NUM_BTN-1:0] BTN_LEVEL,
   output logic [NUM_BTN-1:0] BTN_PRESS,
   output logic [NUM_BTN-1:0] BTN_RELEASE
);

   // One self-contained channel per button pin.
   for (genvar g = 0; g < NUM_BTN; g++) begin : gChannel
      zybo_btn_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) uChannel (
         .clk      (CLK),
         .rst_n    (RST),
         .i_btn    (BTN[g]),
         .o_level  (BTN_LEVEL[g]),
         .o_press  (BTN_PRESS[g]),
         .o_release(BTN_RELEASE[g])
      );
   end

endmodule

// File: tb/tb_zybo_btn_debounce.sv
// Directed bench for zybo_btn_debounce with an 8-cycle debounce window.
module tb_zybo_btn_debounce;

   localparam int NUM_BTN = 4;
   localparam int DEB     = 8;
   localparam int CNT_W   = 4;
   localparam int LAT     = DEB + 3;

   logic               CLK;
   logic               RST;
   logic [NUM_BTN-1:0] BTN;
   logic [NUM_BTN-1:0] BTN_LEVEL;
   logic [NUM_BTN-1:0] BTN_PRESS;
   logic [NUM_BTN-1:0] BTN_RELEASE;

   int total;
   int bad;

   typedef struct {
      logic [3:0] btn;
      int         cycles;
      logic [3:0] expLevel;
      logic [3:0] expPress;
      logic [3:0] expRelease;
      string      name;
   } vec_t;

   vec_t vecs[$];

   zybo_btn_debounce #(
      .NUM_BTN        (NUM_BTN),
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W          (CNT_W)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .BTN        (BTN),
      .BTN_LEVEL  (BTN_LEVEL),
      .BTN_PRESS  (BTN_PRESS),
      .BTN_RELEASE(BTN_RELEASE)
   );

   // 125 MHz board clock.
   initial CLK = 1'b0;
   always #4 CLK = ~CLK;

   task automatic stepCycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] btn, input int cycles);
      BTN = btn;
      stepCycles(cycles);
   endtask

   task automatic checkOutput(input string name, input logic [3:0] expLevel,
                              input logic [3:0] expPress, input logic [3:0] expRelease);
      total++;
      if (BTN_LEVEL !== expLevel) begin
         bad++;
         $display("[TB] FAIL %s level got=%h want=%h", name, BTN_LEVEL, expLevel);
      end
      total++;
      if (BTN_PRESS !== expPress) begin
         bad++;
         $display("[TB] FAIL %s press got=%h want=%h", name, BTN_PRESS, expPress);
      end
      total++;
      if (BTN_RELEASE !== expRelease) begin
         bad++;
         $display("[TB] FAIL %s release got=%h want=%h", name, BTN_RELEASE, expRelease);
      end
   endtask

   // Hold btn for n cycles expecting quiet, unchanged outputs on every cycle.
   task automatic holdQuiet(input string name, input logic [3:0] btn, input int n,
                            input logic [3:0] expLevel);
      BTN = btn;
      for (int i = 0; i < n; i++) begin
         stepCycles(1);
         checkOutput(name, expLevel, 4'h0, 4'h0);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;

      // Test 1: buttons held through reset.
      BTN = 4'hF;
      RST = 1'b1;
      #2;
      RST = 1'b0;
      #1;
      checkOutput("rst_async", 4'h0, 4'h0, 4'h0);
      stepCycles(3);
      checkOutput("rst_held", 4'h0, 4'h0, 4'h0);
      RST = 1'b1;
      stepCycles(LAT - 1);
      checkOutput("rst_pre", 4'h0, 4'h0, 4'h0);
      stepCycles(1);
      checkOutput("rst_press", 4'hF, 4'hF, 4'h0);
      stepCycles(1);
      checkOutput("rst_after", 4'hF, 4'h0, 4'h0);

      // Table: full release, clean press, simultaneous change, release back.
      vecs.push_back('{4'h0, LAT - 1, 4'hF, 4'h0, 4'h0, "relAll_pre"});
      vecs.push_back('{4'h0, 1,       4'h0, 4'h0, 4'hF, "relAll"});
      vecs.push_back('{4'h0, 1,       4'h0, 4'h0, 4'h0, "relAll_after"});
      vecs.push_back('{4'h1, LAT - 1, 4'h0, 4'h0, 4'h0, "clean_pre"});
      vecs.push_back('{4'h1, 1,       4'h1, 4'h1, 4'h0, "clean_press"});
      vecs.push_back('{4'h1, 1,       4'h1, 4'h0, 4'h0, "clean_after"});
      vecs.push_back('{4'h3, LAT - 1, 4'h1, 4'h0, 4'h0, "settle3_pre"});
      vecs.push_back('{4'h3, 1,       4'h3, 4'h2, 4'h0, "settle3"});
      vecs.push_back('{4'h3, 1,       4'h3, 4'h0, 4'h0, "settle3_after"});
      vecs.push_back('{4'hC, LAT - 1, 4'h3, 4'h0, 4'h0, "swap_pre"});
      vecs.push_back('{4'hC, 1,       4'hC, 4'hC, 4'h3, "swap"});
      vecs.push_back('{4'hC, 1,       4'hC, 4'h0, 4'h0, "swap_after"});
      vecs.push_back('{4'h0, LAT,     4'h0, 4'h0, 4'hC, "clear"});
      vecs.push_back('{4'h0, 1,       4'h0, 4'h0, 4'h0, "clear_after"});
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].btn, vecs[i].cycles);
         checkOutput(vecs[i].name, vecs[i].expLevel, vecs[i].expPress, vecs[i].expRelease);
      end

      // Test 3: bounce on BTN[1], then held high.
      for (int p = 0; p < 2; p++) begin
         holdQuiet("bounce_hi", 4'h2, 3, 4'h0);
         holdQuiet("bounce_lo", 4'h0, 3, 4'h0);
      end
      holdQuiet("bounce_settle", 4'h2, LAT - 1, 4'h0);
      stepCycles(1);
      checkOutput("bounce_press", 4'h2, 4'h2, 4'h0);
      stepCycles(1);
      checkOutput("bounce_after", 4'h2, 4'h0, 4'h0);

      // Test 4: 7-cycle pulse on BTN[2] never qualifies.
      holdQuiet("short_hi", 4'h6, 7, 4'h2);
      holdQuiet("short_lo", 4'h2, 3 * LAT, 4'h2);

      // Test 6: reset during WAIT on BTN[3].
      holdQuiet("midwait", 4'hA, 5, 4'h2);
      RST = 1'b0;
      #1;
      checkOutput("midwait_rst", 4'h0, 4'h0, 4'h0);
      stepCycles(2);
      RST = 1'b1;
      holdQuiet("midwait_requal", 4'hA, LAT - 1, 4'h0);
      stepCycles(1);
      checkOutput("midwait_press", 4'hA, 4'hA, 4'h0);
      stepCycles(1);
      checkOutput("midwait_after", 4'hA, 4'h0, 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
